// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback port arbiter.
package wb_pkg;

  localparam int unsigned WB_AGE_LIMIT_DEF = 4;
  localparam int unsigned WB_AGE_W_DEF     = 3;
  localparam int unsigned WB_RD_W          = 5;
  localparam int unsigned WB_DATA_W        = 32;

  typedef enum logic [1:0] {
    WB_PIPE = 2'b00,
    WB_LSU  = 2'b01,
    WB_UART = 2'b10
  } wb_src_e;

  typedef struct packed {
    logic                 valid;
    logic [WB_RD_W-1:0]   rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_age_ctr.sv
// Saturating age counter: counts lost arbitration cycles, clear has priority.
module wb_age_ctr #(
  parameter int unsigned AGE_LIMIT = 4,
  parameter int unsigned AGE_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [AGE_W-1:0] o_age
);

  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(AGE_LIMIT);

  logic [AGE_W-1:0] r_age;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (i_clr) begin
      r_age <= '0;
    end else if (i_inc && (r_age < LIMIT)) begin
      r_age <= r_age + AGE_W'(1);
    end
  end

  assign o_age = r_age;

endmodule

// File: rtl/wb_port_arbiter.sv
// Fixed-priority writeback port arbiter with aging for LSU/UART, plus the
// registered register-file write stage.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned AGE_LIMIT = WB_AGE_LIMIT_DEF,
  parameter int unsigned AGE_W     = WB_AGE_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        uart_valid,
  input  logic [4:0]  uart_rd,
  input  logic [31:0] uart_data,
  output logic        pipe_ready,
  output logic        lsu_ready,
  output logic        uart_ready,
  output logic [1:0]  wb_sel,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall
);

  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(AGE_LIMIT);

  wb_req_t              w_pipe, w_lsu, w_uart;
  logic [AGE_W-1:0]     w_lsu_age, w_uart_age;
  logic                 w_lsu_prom, w_uart_prom;
  logic                 w_pipe_gnt, w_lsu_gnt, w_uart_gnt, w_any_gnt;
  wb_src_e              w_src;
  logic [WB_RD_W-1:0]   w_win_rd;
  logic [WB_DATA_W-1:0] w_win_data;

  wb_src_e              r_wb_sel;
  logic                 r_rf_we;
  logic [WB_RD_W-1:0]   r_rf_waddr;
  logic [WB_DATA_W-1:0] r_rf_wdata;

  assign w_pipe = '{valid: pipe_valid, rd: pipe_rd, data: pipe_data};
  assign w_lsu  = '{valid: lsu_valid,  rd: lsu_rd,  data: lsu_data};
  assign w_uart = '{valid: uart_valid, rd: uart_rd, data: uart_data};

  assign w_lsu_prom  = w_lsu.valid  && (w_lsu_age  >= LIMIT);
  assign w_uart_prom = w_uart.valid && (w_uart_age >= LIMIT);

  // Promoted LSU, promoted UART, then pipeline > LSU > UART.
  always_comb begin
    w_pipe_gnt = 1'b0;
    w_lsu_gnt  = 1'b0;
    w_uart_gnt = 1'b0;
    w_src      = r_wb_sel;
    w_win_rd   = '0;
    w_win_data = '0;
    if (w_lsu_prom) begin
      w_lsu_gnt = 1'b1;
    end else if (w_uart_prom) begin
      w_uart_gnt = 1'b1;
    end else if (w_pipe.valid) begin
      w_pipe_gnt = 1'b1;
    end else if (w_lsu.valid) begin
      w_lsu_gnt = 1'b1;
    end else if (w_uart.valid) begin
      w_uart_gnt = 1'b1;
    end
    if (w_pipe_gnt) begin
      w_src      = WB_PIPE;
      w_win_rd   = w_pipe.rd;
      w_win_data = w_pipe.data;
    end else if (w_lsu_gnt) begin
      w_src      = WB_LSU;
      w_win_rd   = w_lsu.rd;
      w_win_data = w_lsu.data;
    end else if (w_uart_gnt) begin
      w_src      = WB_UART;
      w_win_rd   = w_uart.rd;
      w_win_data = w_uart.data;
    end
  end

  assign w_any_gnt = w_pipe_gnt | w_lsu_gnt | w_uart_gnt;

  wb_age_ctr #(.AGE_LIMIT(AGE_LIMIT), .AGE_W(AGE_W)) u_lsu_age (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_lsu.valid && !w_lsu_gnt),
    .i_clr (!w_lsu.valid || w_lsu_gnt),
    .o_age (w_lsu_age)
  );

  wb_age_ctr #(.AGE_LIMIT(AGE_LIMIT), .AGE_W(AGE_W)) u_uart_age (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_uart.valid && !w_uart_gnt),
    .i_clr (!w_uart.valid || w_uart_gnt),
    .o_age (w_uart_age)
  );

  // Writes to x0 are dropped; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_sel   <= WB_PIPE;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_any_gnt) begin
      r_wb_sel   <= w_src;
      r_rf_we    <= |w_win_rd;
      r_rf_waddr <= w_win_rd;
      r_rf_wdata <= w_win_data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign pipe_ready = w_pipe_gnt;
  assign lsu_ready  = w_lsu_gnt;
  assign uart_ready = w_uart_gnt;
  assign pipe_stall = w_pipe.valid && !w_pipe_gnt;
  // Mux select is forced to the reset value while in reset.
  assign wb_sel     = (rst_n && w_any_gnt) ? w_src : r_wb_sel;
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;

  a_pipe_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (pipe_valid && !pipe_ready) |=> pipe_valid);
  a_lsu_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (lsu_valid && !lsu_ready) |=> lsu_valid);
  a_uart_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (uart_valid && !uart_ready) |=> uart_valid);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table plus multi-cycle
// aging / reset sequences, register-file writes checked via a scoreboard.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pv, lv, uv;
  logic [4:0]  prd, lrd, urd;
  logic [31:0] pd, ld, ud;
  logic        pipe_ready, lsu_ready, uart_ready, rf_we, pipe_stall;
  logic [1:0]  wb_sel;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_exp_t;

  typedef struct {
    string       name;
    logic        pv, lv, uv;
    logic [4:0]  prd, lrd, urd;
    logic [31:0] pd, ld, ud;
    logic [2:0]  rdy;
    logic [1:0]  sel;
    logic        stall;
  } vec_t;

  rf_exp_t     sb_q[$];
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  vec_t        tbl[6];

  always #5 clk = ~clk;

  wb_port_arbiter #(.AGE_LIMIT(4), .AGE_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_valid (pv),
    .pipe_rd    (prd),
    .pipe_data  (pd),
    .lsu_valid  (lv),
    .lsu_rd     (lrd),
    .lsu_data   (ld),
    .uart_valid (uv),
    .uart_rd    (urd),
    .uart_data  (ud),
    .pipe_ready (pipe_ready),
    .lsu_ready  (lsu_ready),
    .uart_ready (uart_ready),
    .wb_sel     (wb_sel),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pipe_stall (pipe_stall)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input string name, input logic [2:0] e_rdy,
                      input logic [1:0] e_sel, input logic e_stall);
    rf_exp_t e;
    #2;
    chk({name, " ready"}, 32'({pipe_ready, lsu_ready, uart_ready}), 32'(e_rdy));
    chk({name, " wb_sel"}, 32'(wb_sel), 32'(e_sel));
    chk({name, " pipe_stall"}, 32'(pipe_stall), 32'(e_stall));
    e.we = 1'b0; e.addr = m_addr; e.data = m_data;
    if (e_rdy == 3'b100) begin
      e.we = (prd != 5'd0); e.addr = prd; e.data = pd;
    end else if (e_rdy == 3'b010) begin
      e.we = (lrd != 5'd0); e.addr = lrd; e.data = ld;
    end else if (e_rdy == 3'b001) begin
      e.we = (urd != 5'd0); e.addr = urd; e.data = ud;
    end
    m_addr = e.addr;
    m_data = e.data;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({name, " rf_we"}, 32'(rf_we), 32'(e.we));
    chk({name, " rf_waddr"}, 32'(rf_waddr), 32'(e.addr));
    chk({name, " rf_wdata"}, rf_wdata, e.data);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    pv = 1'b0; lv = 1'b0; uv = 1'b0;
    prd = '0; lrd = '0; urd = '0;
    pd = '0; ld = '0; ud = '0;
  endtask

  task automatic reset_pulse(input string name);
    clear_inputs();
    rst_n = 1'b0;
    #2;
    chk({name, " rst rf_we"}, 32'(rf_we), 32'd0);
    chk({name, " rst rf_waddr"}, 32'(rf_waddr), 32'd0);
    chk({name, " rst rf_wdata"}, rf_wdata, 32'd0);
    chk({name, " rst wb_sel"}, 32'(wb_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_addr = '0;
    m_data = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    m_addr = '0;
    m_data = '0;

    tbl[0] = '{"single_lsu", 1'b0, 1'b1, 1'b0, 5'd0, 5'd5, 5'd0,
               32'h0, 32'hDEADBEEF, 32'h0, 3'b010, 2'b01, 1'b0};
    tbl[1] = '{"all_three", 1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3,
               32'h11111111, 32'h22222222, 32'h33333333, 3'b100, 2'b00, 1'b0};
    tbl[2] = '{"x0_pipe", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0,
               32'h1234, 32'h0, 32'h0, 3'b100, 2'b00, 1'b0};
    tbl[3] = '{"lsu_uart", 1'b0, 1'b1, 1'b1, 5'd0, 5'd7, 5'd8,
               32'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b010, 2'b01, 1'b0};
    tbl[4] = '{"uart_only", 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd31,
               32'h0, 32'h0, 32'hFEEDFACE, 3'b001, 2'b10, 1'b0};
    tbl[5] = '{"pipe_uart", 1'b1, 1'b0, 1'b1, 5'd12, 5'd0, 5'd13,
               32'h0BADF00D, 32'h0, 32'h13131313, 3'b100, 2'b00, 1'b0};

    @(negedge clk);
    reset_pulse("init");

    for (int i = 0; i < 6; i++) begin
      pv = tbl[i].pv; lv = tbl[i].lv; uv = tbl[i].uv;
      prd = tbl[i].prd; lrd = tbl[i].lrd; urd = tbl[i].urd;
      pd = tbl[i].pd; ld = tbl[i].ld; ud = tbl[i].ud;
      step(tbl[i].name, tbl[i].rdy, tbl[i].sel, tbl[i].stall);
      reset_pulse(tbl[i].name);
    end

    // LSU promoted after four lost cycles under continuous pipeline traffic.
    pv = 1'b1; prd = 5'd1; lv = 1'b1; lrd = 5'd2; ld = 32'hC0DE0002;
    for (int i = 0; i < 4; i++) begin
      pd = 32'h100 + 32'(i);
      step("aging_pipe", 3'b100, 2'b00, 1'b0);
    end
    pd = 32'h104;
    step("aging_lsu", 3'b010, 2'b01, 1'b1);
    lv = 1'b0;
    step("aging_after", 3'b100, 2'b00, 1'b0);
    reset_pulse("aging");

    // Both promoted together: LSU first, UART next cycle.
    pv = 1'b1; prd = 5'd4; pd = 32'h44;
    lv = 1'b1; lrd = 5'd5; ld = 32'h55;
    uv = 1'b1; urd = 5'd6; ud = 32'h66;
    for (int i = 0; i < 4; i++) step("dbl_pipe", 3'b100, 2'b00, 1'b0);
    step("dbl_lsu", 3'b010, 2'b01, 1'b1);
    ld = 32'h56;
    step("dbl_uart", 3'b001, 2'b10, 1'b1);
    uv = 1'b0;
    step("dbl_after", 3'b100, 2'b00, 1'b0);
    reset_pulse("dbl");

    // wb_sel and rf address/data hold when idle; x0 from LSU drops the write.
    uv = 1'b1; urd = 5'd31; ud = 32'hCAFEF00D;
    step("hold_uart", 3'b001, 2'b10, 1'b0);
    uv = 1'b0;
    step("hold_idle", 3'b000, 2'b10, 1'b0);
    lv = 1'b1; lrd = 5'd0; ld = 32'h77;
    step("hold_lsu_x0", 3'b010, 2'b01, 1'b0);
    lv = 1'b0;
    step("hold_idle2", 3'b000, 2'b01, 1'b0);
    reset_pulse("hold");

    // Reset while UART has aged to 3; its age must restart from 0.
    pv = 1'b1; prd = 5'd3; pd = 32'h33;
    uv = 1'b1; urd = 5'd9; ud = 32'h99;
    for (int i = 0; i < 3; i++) step("mid_pre", 3'b100, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid rst rf_we", 32'(rf_we), 32'd0);
    chk("mid rst rf_waddr", 32'(rf_waddr), 32'd0);
    chk("mid rst wb_sel", 32'(wb_sel), 32'd0);
    chk("mid rst ready", 32'({pipe_ready, lsu_ready, uart_ready}), 32'(3'b100));
    @(negedge clk);
    rst_n = 1'b1;
    m_addr = '0;
    m_data = '0;
    for (int i = 0; i < 4; i++) step("mid_post_pipe", 3'b100, 2'b00, 1'b0);
    step("mid_post_uart", 3'b001, 2'b10, 1'b1);
    reset_pulse("mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
